usb_gpx_event_ctrl: RTL

Avalon-MM controller for the MAX3421E GPX pin, replacing the bare level-read port with a managed event source. It synchronizes and glitch-filters the GPX input, captures enabled rising and falling edges into sticky write-1-to-clear flags, counts events, and raises a level interrupt to the Nios II. It sits on the same Avalon bus as the other USB peripherals, and software services GPX events by interrupt instead of polling.

---
 rtl/usb_gpx_pkg.sv | 21 ++
 rtl/usb_gpx_filter.sv | 54 +++++
 rtl/usb_gpx_event_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/usb_gpx_pkg.sv
// Shared constants for the GPX event controller: register map, bit positions and default widths.
package usb_gpx_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_CTRL  = 2'd1;
  localparam logic [1:0] ADDR_EVENT = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  localparam int unsigned CTRL_RISE_EN  = 0;
  localparam int unsigned CTRL_FALL_EN  = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_FILT_LSB = 8;

  localparam int unsigned EVT_RISE = 0;
  localparam int unsigned EVT_FALL = 1;
  localparam int unsigned EVT_OVF  = 2;

  localparam int unsigned DEFAULT_FILT_W = 8;
  localparam int unsigned DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/usb_gpx_filter.sv
// Two-flop synchronizer, glitch filter and edge detect for the GPX pin.
module usb_gpx_filter
  import usb_gpx_pkg::*;
#(
  parameter int unsigned FILT_W = DEFAULT_FILT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_port,
  input  logic [FILT_W-1:0] filt_len,
  output logic              level,
  output logic              rise,
  output logic              fall
);

  logic              sync1_q, sync2_q;
  logic              filt_q, filt_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic              take;

  // >= rather than == so a shortened filter length still lets a running count complete.
  always_comb begin
    take   = 1'b0;
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q >= filt_len) begin
        take   = 1'b1;
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = filt_q;
  assign rise  = take & sync2_q;
  assign fall  = take & ~sync2_q;

endmodule

// File: rtl/usb_gpx_event_ctrl.sv
// Avalon-MM GPX event controller: CTRL/EVENT/COUNT registers, level irq and registered read mux.
module usb_gpx_event_ctrl
  import usb_gpx_pkg::*;
#(
  parameter int unsigned FILT_W = DEFAULT_FILT_W,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        irq
);

  logic [2:0]        ctrl_q, ctrl_d;
  logic [FILT_W-1:0] filt_len_q, filt_len_d;
  logic [2:0]        event_q, event_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [31:0]       rdata;
  logic              level, rise, fall;
  logic              wr, rd, rise_ev, fall_ev, ovf_set;
  logic [2:0]        clr;
  logic              unused_wdata;

  usb_gpx_filter #(
    .FILT_W (FILT_W)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .in_port  (in_port),
    .filt_len (filt_len_q),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  assign unused_wdata = ^writedata;

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_DATA:  rdata[0] = level;
      ADDR_CTRL: begin
        rdata[2:0]                     = ctrl_q;
        rdata[CTRL_FILT_LSB +: FILT_W] = filt_len_q;
      end
      ADDR_EVENT: rdata[2:0] = event_q;
      ADDR_COUNT: rdata[CNT_W-1:0] = count_q;
      default: ;
    endcase
  end

  always_comb begin
    wr      = chipselect & write;
    rd      = chipselect & read;
    // Edges are qualified by the registered enables, so a same-cycle CTRL write lands too late.
    rise_ev = rise & ctrl_q[CTRL_RISE_EN];
    fall_ev = fall & ctrl_q[CTRL_FALL_EN];
    clr     = (wr && address == ADDR_EVENT) ? writedata[2:0] : 3'b000;

    // A re-set that coincides with a clear of the same flag is a fresh event, not an overflow.
    ovf_set = (rise_ev & event_q[EVT_RISE] & ~clr[EVT_RISE]) |
              (fall_ev & event_q[EVT_FALL] & ~clr[EVT_FALL]);
    event_d[EVT_RISE] = (event_q[EVT_RISE] & ~clr[EVT_RISE]) | rise_ev;
    event_d[EVT_FALL] = (event_q[EVT_FALL] & ~clr[EVT_FALL]) | fall_ev;
    event_d[EVT_OVF]  = (event_q[EVT_OVF] & ~clr[EVT_OVF]) | ovf_set;

    ctrl_d     = ctrl_q;
    filt_len_d = filt_len_q;
    if (wr && address == ADDR_CTRL) begin
      ctrl_d     = writedata[2:0];
      filt_len_d = writedata[CTRL_FILT_LSB +: FILT_W];
    end

    count_d = count_q;
    if (wr && address == ADDR_COUNT) begin
      count_d = '0;
    end else if ((rise_ev | fall_ev) && !(&count_q)) begin
      count_d = count_q + CNT_W'(1);
    end

    readdata_d = rd ? rdata : readdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      filt_len_q <= '0;
      event_q    <= '0;
      count_q    <= '0;
      readdata_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      filt_len_q <= filt_len_d;
      event_q    <= event_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = ctrl_q[CTRL_IRQ_EN] & (event_q[EVT_RISE] | event_q[EVT_FALL]);

endmodule
